// File: rtl/i2c_host_bridge.sv
// Host strobe bridge to the I2C byte engine: register file, TX/RX FIFOs,
// latched W1C interrupt status and a one-cycle dtack handshake.
module i2c_host_bridge #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              as,
   input  logic              ds,
   input  logic              rw,
   input  logic [ADDR_W-1:0] add_bus,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              dtack,
   output logic              irq,
   output logic              core_en,
   output logic              inter_en,
   output logic              mode,
   output logic              master_rw,
   output logic              ack,
   output logic              rep_start,
   output logic              halt,
   output logic [DATA_W-1:0] prescale,
   output logic [DATA_W-1:0] time_out_reg,
   output logic [DATA_W-1:0] slave_add,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_pop,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_push,
   input  logic              byte_trans,
   input  logic              slave_addressed,
   input  logic              bus_busy,
   input  logic              arb_lost,
   input  logic              time_out,
   input  logic              slave_rw,
   input  logic              inter,
   input  logic              ack_rec,
   input  logic              time_rst
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] A_RR = 'h00, A_PRER = 'h02, A_CTR = 'h04,
      A_SR = 'h08, A_TO = 'h0A, A_ADDR = 'h0C, A_DR = 'h0E, A_ISR = 'h10,
      A_IMR = 'h12, A_FSR = 'h14;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_HOLD} state_t;
   state_t state_q, state_d;

   logic as_m_q, as_s_q, ds_m_q, ds_s_q, ds_p_q, rw_q, start;
   logic [ADDR_W-1:0] adr_q;
   logic [7:0] ctr_q, imr_q;
   logic [5:0] isr_q, isr_set, isr_clr;
   logic [DATA_W-1:0] prer_q, tor_q, sadr_q, dout_q, rdata;
   logic bt_q, al_q, tm_q, sa_q, irq_q, bt_fall;
   logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
   logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   logic [CW-1:0] tx_cnt_q, rx_cnt_q;
   logic acc, wr, rd, tx_push, tx_do_push, tx_do_pop, rx_do_push, rx_do_pop;

   assign start = as_s_q & ds_s_q & ~ds_p_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_ACCESS;
         S_ACCESS: state_d = S_ACK;
         S_ACK:    state_d = S_HOLD;
         S_HOLD:   if (!ds_s_q) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign acc        = (state_q == S_ACCESS);
   assign wr         = acc & rw_q & ~time_rst;
   assign rd         = acc & ~rw_q;
   assign tx_push    = wr & (adr_q == A_DR);
   assign tx_do_push = tx_push & (tx_cnt_q != FULL);
   assign tx_do_pop  = tx_pop & (tx_cnt_q != '0);
   assign rx_do_push = rx_push & (rx_cnt_q != FULL);
   assign rx_do_pop  = rd & (adr_q == A_RR) & (rx_cnt_q != '0);
   assign bt_fall    = bt_q & ~byte_trans;

   assign isr_set = {tx_push & (tx_cnt_q == FULL), slave_addressed & ~sa_q,
                     rx_push & (rx_cnt_q == FULL), time_out & ~tm_q,
                     arb_lost & ~al_q, bt_fall};
   assign isr_clr = (wr && adr_q == A_ISR) ? data_in[5:0] : 6'd0;

   always_comb begin
      rdata = '0;
      unique case (adr_q)
         A_RR:    if (rx_cnt_q != '0) rdata = rx_mem_q[rx_rp_q];
         A_PRER:  rdata = prer_q;
         A_CTR:   rdata = DATA_W'(ctr_q);
         A_SR:    rdata = DATA_W'({byte_trans, slave_addressed, bus_busy,
                                   arb_lost, time_out, slave_rw, inter,
                                   ack_rec});
         A_TO:    rdata = tor_q;
         A_ADDR:  rdata = sadr_q;
         A_ISR:   rdata = DATA_W'({2'b00, isr_q});
         A_IMR:   rdata = DATA_W'(imr_q);
         A_FSR:   rdata = DATA_W'({rx_cnt_q, tx_cnt_q});
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         {as_m_q, as_s_q, ds_m_q, ds_s_q, ds_p_q, rw_q} <= '0;
         {bt_q, al_q, tm_q, sa_q, irq_q} <= '0;
         adr_q  <= '0;
         dout_q <= '0;
      end else begin
         state_q <= state_d;
         as_m_q  <= as;
         as_s_q  <= as_m_q;
         ds_m_q  <= ds;
         ds_s_q  <= ds_m_q;
         ds_p_q  <= ds_s_q;
         bt_q    <= byte_trans;
         al_q    <= arb_lost;
         tm_q    <= time_out;
         sa_q    <= slave_addressed;
         irq_q   <= ctr_q[6] & |({2'b00, isr_q} & imr_q);
         if (state_q == S_IDLE && start) begin
            adr_q <= add_bus;
            rw_q  <= rw;
         end
         if (rd) dout_q <= rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {ctr_q, imr_q} <= '0;
         isr_q  <= '0;
         {prer_q, tor_q, sadr_q} <= '0;
      end else begin
         if (wr && adr_q == A_IMR) imr_q <= data_in[7:0];
         if (wr && adr_q == A_ADDR) sadr_q <= data_in & ~DATA_W'(1);
         if (time_rst) begin
            ctr_q  <= '0;
            isr_q  <= '0;
            prer_q <= '0;
            tor_q  <= '0;
         end else begin
            isr_q <= (isr_q & ~isr_clr) | isr_set;
            if (wr && adr_q == A_PRER) prer_q <= data_in;
            if (wr && adr_q == A_TO) tor_q <= data_in;
            if (wr && adr_q == A_CTR) ctr_q <= data_in[7:0] & 8'hFD;
            else if (bt_fall) ctr_q <= ctr_q & 8'hFA;
         end
      end
   end

   // Memories are cleared too so tx_data and RR reads never expose stale bytes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q} <= '0;
         {tx_cnt_q, rx_cnt_q} <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
      end else if (time_rst) begin
         {tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q} <= '0;
         {tx_cnt_q, rx_cnt_q} <= '0;
      end else begin
         if (tx_do_push) begin
            tx_mem_q[tx_wp_q] <= data_in;
            tx_wp_q <= tx_wp_q + 1'b1;
         end
         if (tx_do_pop) tx_rp_q <= tx_rp_q + 1'b1;
         tx_cnt_q <= tx_cnt_q + CW'(tx_do_push) - CW'(tx_do_pop);
         if (rx_do_push) begin
            rx_mem_q[rx_wp_q] <= rx_data;
            rx_wp_q <= rx_wp_q + 1'b1;
         end
         if (rx_do_pop) rx_rp_q <= rx_rp_q + 1'b1;
         rx_cnt_q <= rx_cnt_q + CW'(rx_do_push) - CW'(rx_do_pop);
      end
   end

   assign dtack        = (state_q == S_ACK);
   assign data_out     = dout_q;
   assign irq          = irq_q;
   assign core_en      = ctr_q[7];
   assign inter_en     = ctr_q[6];
   assign mode         = ctr_q[5];
   assign master_rw    = ctr_q[4];
   assign ack          = ctr_q[3];
   assign rep_start    = ctr_q[2];
   assign halt         = ctr_q[0];
   assign prescale     = prer_q;
   assign time_out_reg = tor_q;
   assign slave_add    = sadr_q;
   assign tx_valid     = (tx_cnt_q != '0);
   assign tx_data      = tx_valid ? tx_mem_q[tx_rp_q] : '0;
endmodule

// File: tb/tb_i2c_host_bridge.sv
// Directed bench for i2c_host_bridge: strobe timing, FIFOs, ISR/irq,
// CTR self-clear, soft clear and reset abort.
module tb_i2c_host_bridge;
   logic clk = 0, rst = 0;
   logic as = 0, ds = 0, rw = 0;
   logic [7:0] add_bus = 0, data_in = 0, data_out;
   logic dtack, irq, core_en, inter_en, mode, master_rw, ack, rep_start, halt;
   logic [7:0] prescale, time_out_reg, slave_add, tx_data, rx_data = 0;
   logic tx_valid, tx_pop = 0, rx_push = 0;
   logic byte_trans = 0, slave_addressed = 0, bus_busy = 0, arb_lost = 0;
   logic time_out = 0, slave_rw = 0, inter = 0, ack_rec = 0, time_rst = 0;
   int total = 0, bad = 0;
   logic last_w;
   logic [7:0] q;
   int lat;

   always #5 clk = ~clk;

   i2c_host_bridge dut (
      .clk(clk), .rst(rst), .as(as), .ds(ds), .rw(rw), .add_bus(add_bus),
      .data_in(data_in), .data_out(data_out), .dtack(dtack), .irq(irq),
      .core_en(core_en), .inter_en(inter_en), .mode(mode),
      .master_rw(master_rw), .ack(ack), .rep_start(rep_start), .halt(halt),
      .prescale(prescale), .time_out_reg(time_out_reg),
      .slave_add(slave_add), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_pop(tx_pop), .rx_data(rx_data), .rx_push(rx_push),
      .byte_trans(byte_trans), .slave_addressed(slave_addressed),
      .bus_busy(bus_busy), .arb_lost(arb_lost), .time_out(time_out),
      .slave_rw(slave_rw), .inter(inter), .ack_rec(ack_rec),
      .time_rst(time_rst)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic coll,
                      output logic [7:0] r, output int l);
      @(negedge clk);
      add_bus = a; data_in = d; rw = w; as = 1;
      @(negedge clk);
      ds = 1;
      l = 0;
      do begin
         @(posedge clk); #1;
         l++;
         if (coll && l == 3) byte_trans = 0;
      end while (!dtack && l < 20);
      if (l >= 20) chk("dtack_timeout", dtack, 1);
      r = data_out;
      @(posedge clk); #1;
      last_w = dtack;
      @(negedge clk);
      ds = 0; as = 0; rw = 0;
      repeat (5) @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      logic [7:0] r;
      int l;
      bus(1, a, d, 0, r, l);
   endtask

   task automatic rd(input string tag, input logic [7:0] a,
                     input logic [7:0] e);
      logic [7:0] r;
      int l;
      bus(0, a, 8'h00, 0, r, l);
      chk(tag, r, e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      cyc(3);
      chk("rst_outs", {data_out, dtack, irq, tx_valid, tx_data},
          {8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
      chk("rst_regs", {prescale, time_out_reg, slave_add}, 24'h0);
      chk("rst_ctr", {core_en, inter_en, mode, master_rw, ack, rep_start,
          halt}, 7'h0);
      rst = 1;
      cyc(3);

      wr(8'h02, 8'hA5);
      chk("prer_out", prescale, 8'hA5);
      bus(0, 8'h02, 8'h00, 0, q, lat);
      chk("prer_rd", q, 8'hA5);
      chk("dtack_lat", lat, 4);
      chk("dtack_width", last_w, 0);

      for (int i = 0; i < 5; i++) wr(8'h0E, 8'h11 + 8'(i));
      rd("fsr_tx4", 8'h14, 8'h04);
      rd("isr_txovf", 8'h10, 8'h20);
      for (int i = 0; i < 4; i++) begin
         chk("tx_valid", tx_valid, 1);
         chk("tx_head", tx_data, 8'h11 + 8'(i));
         tx_pop = 1;
         cyc(1);
         tx_pop = 0;
      end
      chk("tx_empty", tx_valid, 0);
      wr(8'h10, 8'h20);
      rd("isr_clr5", 8'h10, 8'h00);

      rx_data = 8'h3C; rx_push = 1; cyc(1);
      rx_data = 8'h3D; cyc(1);
      rx_push = 0;
      rd("fsr_rx2", 8'h14, 8'h10);
      rd("rr0", 8'h00, 8'h3C);
      rd("fsr_rx1", 8'h14, 8'h08);
      rd("rr1", 8'h00, 8'h3D);
      rd("fsr_rx0", 8'h14, 8'h00);
      rd("rr_empty", 8'h00, 8'h00);

      wr(8'h12, 8'h01);
      wr(8'h04, 8'h40);
      byte_trans = 1; cyc(2);
      byte_trans = 0; cyc(3);
      chk("irq_set", irq, 1);
      rd("isr_bt", 8'h10, 8'h01);
      wr(8'h10, 8'h01);
      chk("irq_clr", irq, 0);
      rd("isr_w1c", 8'h10, 8'h00);
      byte_trans = 1; cyc(2);
      bus(1, 8'h10, 8'h01, 1, q, lat);
      rd("isr_coll", 8'h10, 8'h01);
      chk("irq_coll", irq, 1);

      wr(8'h04, 8'h86);
      chk("ctr_bits", {core_en, inter_en, rep_start, halt}, 4'b1010);
      rd("ctr_rsv", 8'h04, 8'h84);
      byte_trans = 1; cyc(2);
      byte_trans = 0; cyc(3);
      chk("rep_clr", {core_en, rep_start}, 2'b10);
      rd("ctr_after", 8'h04, 8'h80);

      wr(8'h0C, 8'h43);
      chk("sadr", slave_add, 8'h42);
      wr(8'h02, 8'h33);
      wr(8'h0A, 8'h55);
      wr(8'h0E, 8'h77);
      wr(8'h0E, 8'h78);
      rx_data = 8'h99; rx_push = 1; cyc(1); rx_push = 0;
      rd("fsr_pre", 8'h14, 8'h0A);
      time_rst = 1; cyc(1); time_rst = 0;
      cyc(1);
      chk("trst_out", {tx_valid, prescale, time_out_reg, core_en}, 18'h0);
      chk("trst_sadr", slave_add, 8'h42);
      rd("trst_fsr", 8'h14, 8'h00);
      rd("trst_ctr", 8'h04, 8'h00);
      rd("trst_prer", 8'h02, 8'h00);
      rd("trst_to", 8'h0A, 8'h00);
      rd("trst_isr", 8'h10, 8'h00);
      rd("trst_imr", 8'h12, 8'h01);
      rd("trst_addr", 8'h0C, 8'h42);

      n = 0;
      ds = 1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (dtack) n++;
      end
      ds = 0;
      cyc(5);
      chk("no_as", n, 0);

      bus(0, 8'h06, 8'h00, 0, q, lat);
      chk("unmap_rd", q, 8'h00);
      chk("unmap_lat", lat, 4);
      bus_busy = 1; ack_rec = 1;
      rd("sr", 8'h08, 8'h21);
      bus_busy = 0; ack_rec = 0;

      wr(8'h02, 8'h5A);
      @(negedge clk);
      add_bus = 8'h02; rw = 0; as = 1;
      @(negedge clk);
      ds = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (dtack) n++;
      end
      chk("abort_dtack", n, 0);
      chk("abort_regs", {prescale, data_out}, 16'h0);
      ds = 0; as = 0;
      cyc(2);
      rst = 1;
      cyc(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2c_host_bridge.md
# i2c_host_bridge

Parametrised processor-to-I2C-core register bridge with a strobe handshake and TX/RX data FIFOs. It sits between the host bus (as/ds/rw strobes) and the I2C byte engine. It holds the control, prescale, timeout and slave-address registers, buffers transmit and receive bytes, and raises a maskable, latched interrupt. It succeeds the single-byte interface. The new behaviour is FIFO buffering, a W1C interrupt status register, and a completion acknowledge (dtack).

## Interface
- ADDR_W, 8, host address width
- DATA_W, 8, host data width; must be ≥ 8 and ≥ 2*(log2(FIFO_DEPTH)+1)
- FIFO_DEPTH, 4, TX and RX depth; power of two, ≥ 2
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; asynchronous and active-low
- as, ds, rw  in  1 each  address strobe, data strobe, 1 = write; all asynchronous to clk
- add_bus  in  ADDR_W  register address; stable while as=1
- data_in  in  DATA_W  write data; stable while ds=1
- data_out  out  DATA_W  read data; valid when dtack=1, held until the next read
- dtack  out  1  access-complete pulse
- irq  out  1  registered interrupt
- core_en, inter_en, mode, master_rw, ack, rep_start, halt  out  1 each  CTR bits 7,6,5,4,3,2,0
- prescale, time_out_reg, slave_add  out  DATA_W  register contents; slave_add bit0 is always 0
- tx_data  out  DATA_W  head of the TX FIFO
- tx_valid  out  1  TX FIFO is not empty
- tx_pop  in  1  core consumes tx_data
- rx_data  in  DATA_W  byte from the core
- rx_push  in  1  core writes rx_data into the RX FIFO
- byte_trans, slave_addressed, bus_busy, arb_lost, time_out, slave_rw, inter, ack_rec  in  1 each  core status inputs
- time_rst  in  1  synchronous soft clear

## Operation
- Address map:
  - 0x00 RR: RX pop (read)
  - 0x02 PRER
  - 0x04 CTR
  - 0x08 SR: read-only; {byte_trans, slave_addressed, bus_busy, arb_lost, time_out, slave_rw, inter, ack_rec}
  - 0x0A TO
  - 0x0C ADDR
  - 0x0E DR: TX push (write)
  - 0x10 ISR: W1C
  - 0x12 IMR
  - 0x14 FSR: read-only; {rx_count, tx_count}, zero-extended
- Unmapped addresses: reads return 0, writes are ignored, dtack is still issued.
- Register width: CTR, SR, ISR and IMR are 8 bits; upper bits read as 0. CTR bit1 is reserved and reads 0.
- Strobe synchronisation: as and ds each pass through two flops (as_s, ds_s). An access starts on a ds_s rising edge while as_s=1. add_bus is captured at that edge.
- FSM:
  - IDLE → ACCESS on ds_s rise with as_s=1.
  - ACCESS (1 cycle): performs the write or loads data_out.
  - ACCESS → ACK: dtack=1 for exactly one cycle.
  - ACK → HOLD.
  - HOLD → IDLE when ds_s=0.
  - ds rises without as: the strobe is ignored.
- TX FIFO:
  - A DR write pushes data_in.
  - A push while full is dropped and sets ISR[5].
  - tx_pop while empty is ignored.
- RX FIFO:
  - rx_push writes rx_data.
  - A push while full is dropped and sets ISR[3].
  - An RR read pops; an RR read while empty returns 0.
  - Full/empty tests use the pre-edge count. A push and a pop in the same cycle both take effect when neither FIFO is at the boundary.
- Pointers wrap modulo FIFO_DEPTH. Counts run 0..FIFO_DEPTH.
- ISR bit sources:
  - [0] falling edge of byte_trans
  - [1] rising edge of arb_lost
  - [2] rising edge of time_out
  - [3] RX overflow
  - [4] rising edge of slave_addressed
  - [5] TX overflow
- ISR clearing: writing 1 clears a bit. A set and a clear in the same cycle resolve to set.
- irq is registered: irq <= inter_en & |(ISR & IMR).
- rep_start and halt self-clear on a falling edge of byte_trans.
- time_rst clears CTR, PRER, TO, ISR and both FIFOs. It does not clear ADDR or IMR, and does not affect the FSM. A write colliding with time_rst is lost.

## Timing
- Reset (rst=0): all registers and FIFOs are cleared and the FSM returns to IDLE. Every output is 0: data_out, dtack, irq, tx_valid, tx_data, all CTR outputs, prescale, time_out_reg and slave_add.
- Reset mid-access: the access is aborted and no dtack is issued.
- ds sampled high at edge k: ds_s=1 at edge k+2. The register update and data_out load occur at edge k+3. dtack is high during cycle k+3 → k+4.
- Minimum ds low time between accesses: 3 clocks.
- FIFO status (tx_valid, FSR, irq source bits) updates one clock after a push or pop. irq follows one further clock.

## Test plan
- Write 0xA5 to PRER, then read it back → prescale=0xA5; data_out=0xA5 with dtack pulse width 1, exactly 3 clocks after the ds sample.
- Push 5 bytes 0x11..0x15 to DR with FIFO_DEPTH=4 → tx_count=4, ISR[5]=1; four tx_pop pulses deliver 0x11..0x14, then tx_valid=0.
- Pulse rx_push with 0x3C, then 0x3D; read RR three times → returns 0x3C, 0x3D, 0x00; FSR rx_count goes 2→1→0.
- With IMR=0x01 and CTR=0x40, toggle byte_trans 1→0 → ISR[0]=1 and irq=1; write ISR=0x01 → irq=0. A clear that coincides with a new byte_trans fall leaves ISR[0]=1.
- Write CTR=0x84, then drop byte_trans → rep_start falls to 0 while core_en stays 1.
- Assert time_rst with data in both FIFOs and ADDR=0x42 → FIFOs empty, CTR/PRER/TO read 0, slave_add stays 0x42; an access with ds but no as gets no dtack.
